// File: rtl/mini_alu_sched_if.sv
// Handshake bundle between the two ALU requesters, the result consumer and mini_alu_sched.
// master = requesters/consumer side, slave = scheduler side.
interface mini_alu_sched_if #(parameter int WIDTH = 6);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_ovf;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    output rsp_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    input  rsp_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_ovf
  );
endinterface

// File: rtl/mini_alu_sched.sv
// Two-requester scheduler sharing one WIDTH-bit adder for ADD/SUB/NEGA/NEGB; SUB runs as negate-then-add.
// Define MINI_ALU_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mini_alu_sched #(
  parameter int WIDTH = 6
) (
  input logic             clk,
  input logic             rst_n,
  mini_alu_sched_if.slave bus
);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEGA = 2'b10;
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    id_q, id_d;
  logic                    vld_q, vld_d;
  logic                    ovf_q, ovf_d;
  logic [1:0]              op_q, op_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic signed [WIDTH-1:0] temp_q, temp_d, sum_q, sum_d;
  logic                    grant0, grant1;
  logic signed [WIDTH-1:0] add_x, add_y, add_cin, add_sum;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, y, s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x, y, s);
    return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic neg_ovf(input logic signed [WIDTH-1:0] x);
    return x == MOST_NEG;
  endfunction

  // Grants are only made from IDLE and never while reset is held.
`ifdef MINI_ALU_SCHED_FIXED_PRIO_EN
  assign grant0 = rst_n && (state_q == IDLE) && bus.req0_valid;
  assign grant1 = rst_n && (state_q == IDLE) && bus.req1_valid && !bus.req0_valid;
`else
  assign grant0 = rst_n && (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign grant1 = rst_n && (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
`endif

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_ovf    = ovf_q;

  // The single adder instance: operand muxing selects the pass being executed.
  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_cin = '0;
    if (state_q == PASS2) begin
      add_y = temp_q;
    end else if (op_q != OP_ADD) begin
      add_x      = (op_q == OP_NEGA) ? ~a_q : ~b_q;
      add_y      = '0;
      add_cin[0] = 1'b1;
    end
    add_sum = add_x + add_y + add_cin;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    vld_d        = vld_q;
    ovf_d        = ovf_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    temp_d       = temp_q;
    sum_d        = sum_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d = PASS1;
          id_d    = grant1;
          op_d    = grant1 ? bus.req1_op : bus.req0_op;
          a_d     = grant1 ? bus.req1_a  : bus.req0_a;
          b_d     = grant1 ? bus.req1_b  : bus.req0_b;
`ifndef MINI_ALU_SCHED_FIXED_PRIO_EN
          last_grant_d = grant1;
`endif
        end
      end
      PASS1: begin
        if (op_q == OP_SUB) begin
          temp_d  = add_sum;
          state_d = PASS2;
        end else begin
          sum_d   = add_sum;
          ovf_d   = (op_q == OP_ADD)  ? add_ovf(a_q, b_q, add_sum) :
                    (op_q == OP_NEGA) ? neg_ovf(a_q) : neg_ovf(b_q);
          vld_d   = 1'b1;
          state_d = RESP;
        end
      end
      PASS2: begin
        // Overflow uses the original b so that b = most-negative is judged correctly.
        sum_d   = add_sum;
        ovf_d   = sub_ovf(a_q, b_q, add_sum);
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      vld_q        <= 1'b0;
      ovf_q        <= 1'b0;
      temp_q       <= '0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      vld_q        <= vld_d;
      ovf_q        <= ovf_d;
      temp_q       <= temp_d;
      sum_q        <= sum_d;
    end
  end

  // Latched operands need no reset: they are always written before use.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end
endmodule
